// File: rtl/load_tile_2d.sv
// Strided 2D tile loader: reads each row beat-by-beat and packs bytes into TILE_WIDTH-bit tiles, zeroing bytes past the row end.
// First tile_valid BEATS+1 cycles after acceptance/handshake; holds tile and issues no reads while tile_valid && !tile_ready.
module load_tile_2d #(
    parameter int TILE_WIDTH = 256,
    parameter int MEM_BYTES  = 4,
    parameter int ADDR_WIDTH = 24,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_base,
    input  logic [ADDR_WIDTH-1:0]   cmd_stride,
    input  logic [LEN_WIDTH-1:0]    cmd_row_bytes,
    input  logic [LEN_WIDTH-1:0]    cmd_num_rows,
    output logic                    mem_en,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [8*MEM_BYTES-1:0]  mem_rdata,
    output logic [TILE_WIDTH-1:0]   tile_data,
    output logic                    tile_valid,
    input  logic                    tile_ready,
    output logic                    tile_row_last,
    output logic                    tile_last,
    output logic                    done
);

    localparam int NUM_BYTES = TILE_WIDTH / 8;
    localparam int BEATS     = NUM_BYTES / MEM_BYTES;
    localparam int BW        = 8 * MEM_BYTES;
    localparam int CNT_W     = $clog2(BEATS + 2);
    localparam int OFF_W     = LEN_WIDTH + $clog2(NUM_BYTES) + 1;

    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_TWO   = CNT_W'(2);
    localparam logic [CNT_W-1:0] C_BEATS = CNT_W'(BEATS);
    localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(BEATS + 1);
    localparam logic [OFF_W-1:0] O_MB    = OFF_W'(MEM_BYTES);
    localparam logic [OFF_W-1:0] O_NB    = OFF_W'(NUM_BYTES);

    typedef enum logic [1:0] {IDLE, FETCH, OUTPUT, DONE} state_t;

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  row_ptr;
    logic [ADDR_WIDTH-1:0]  stride;
    logic [LEN_WIDTH-1:0]   row_bytes;
    logic [LEN_WIDTH-1:0]   num_rows;
    logic [LEN_WIDTH-1:0]   row_idx;
    logic [OFF_W-1:0]       tile_off;
    logic [CNT_W-1:0]       cnt;

    logic [CNT_W-1:0]       step;
    logic [CNT_W-1:0]       cap_b;
    logic [OFF_W-1:0]       rb_ext;
    logic [OFF_W-1:0]       iss_off;
    logic [OFF_W-1:0]       cap_off;
    logic [OFF_W-1:0]       nxt_off;
    logic [ADDR_WIDTH-1:0]  nxt_ptr;
    logic [BW-1:0]          beat_word;
    logic [TILE_WIDTH-1:0]  tile_nxt;
    logic                   row_last_c;
    logic                   last_row_c;

    // Beat issued on FETCH step s is captured two steps later (read port + data-valid cycle).
    always_comb begin
        step       = cnt + C_ONE;
        cap_b      = step - C_TWO;
        rb_ext     = OFF_W'(row_bytes);
        iss_off    = tile_off + OFF_W'(step) * O_MB;
        cap_off    = tile_off + OFF_W'(cap_b) * O_MB;
        row_last_c = (tile_off + O_NB) >= rb_ext;
        last_row_c = (row_idx + LEN_WIDTH'(1)) == num_rows;
        beat_word  = '0;
        for (int k = 0; k < MEM_BYTES; k++) begin
            if ((cap_off + OFF_W'(k)) < rb_ext)
                beat_word[BW-1-8*k -: 8] = mem_rdata[8*k +: 8];
        end
        tile_nxt = tile_data;
        if (cap_b < C_BEATS)
            tile_nxt[(BEATS-1-int'(cap_b))*BW +: BW] = beat_word;
        if (tile_row_last) begin
            nxt_ptr = row_ptr + stride;
            nxt_off = '0;
        end else begin
            nxt_ptr = row_ptr;
            nxt_off = tile_off + O_NB;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cmd_ready     <= 1'b1;
            mem_en        <= 1'b0;
            mem_addr      <= '0;
            tile_data     <= '0;
            tile_valid    <= 1'b0;
            tile_row_last <= 1'b0;
            tile_last     <= 1'b0;
            done          <= 1'b0;
            row_ptr       <= '0;
            stride        <= '0;
            row_bytes     <= '0;
            num_rows      <= '0;
            row_idx       <= '0;
            tile_off      <= '0;
            cnt           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        row_ptr   <= cmd_base;
                        stride    <= cmd_stride;
                        row_bytes <= cmd_row_bytes;
                        num_rows  <= cmd_num_rows;
                        row_idx   <= '0;
                        tile_off  <= '0;
                        cnt       <= '0;
                        if (cmd_row_bytes == '0 || cmd_num_rows == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= FETCH;
                            mem_en   <= 1'b1;
                            mem_addr <= cmd_base;
                        end
                    end
                end
                FETCH: begin
                    cnt <= step;
                    if (step < C_BEATS) begin
                        mem_en   <= iss_off < rb_ext;
                        mem_addr <= row_ptr + ADDR_WIDTH'(iss_off);
                    end else begin
                        mem_en <= 1'b0;
                    end
                    if (step >= C_TWO)
                        tile_data <= tile_nxt;
                    if (step == C_LAST) begin
                        tile_valid    <= 1'b1;
                        tile_row_last <= row_last_c;
                        tile_last     <= row_last_c && last_row_c;
                        state         <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (tile_ready) begin
                        tile_valid    <= 1'b0;
                        tile_row_last <= 1'b0;
                        tile_last     <= 1'b0;
                        if (tile_last) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            row_ptr  <= nxt_ptr;
                            tile_off <= nxt_off;
                            if (tile_row_last)
                                row_idx <= row_idx + LEN_WIDTH'(1);
                            cnt      <= '0;
                            mem_en   <= 1'b1;
                            mem_addr <= nxt_ptr + ADDR_WIDTH'(nxt_off);
                            state    <= FETCH;
                        end
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_tile_2d.sv
// Randomised scoreboard bench for load_tile_2d (64-bit tiles, 4-byte beats).
module tb_load_tile_2d;
    localparam int TW = 64, MB = 4, AW = 24, LW = 16;
    localparam int NB = TW / 8, BEATS = NB / MB;

    logic            clk = 1'b0, rst;
    logic            cmd_valid, cmd_ready;
    logic [AW-1:0]   cmd_base, cmd_stride;
    logic [LW-1:0]   cmd_row_bytes, cmd_num_rows;
    logic            mem_en;
    logic [AW-1:0]   mem_addr;
    logic [8*MB-1:0] mem_rdata = '0;
    logic [TW-1:0]   tile_data;
    logic            tile_valid, tile_ready = 1'b0, tile_row_last, tile_last, done;

    load_tile_2d #(.TILE_WIDTH(TW), .MEM_BYTES(MB), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_base(cmd_base), .cmd_stride(cmd_stride),
        .cmd_row_bytes(cmd_row_bytes), .cmd_num_rows(cmd_num_rows),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .tile_data(tile_data), .tile_valid(tile_valid), .tile_ready(tile_ready),
        .tile_row_last(tile_row_last), .tile_last(tile_last), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [TW-1:0] data;
        logic          rl;
        logic          l;
    } tile_t;

    tile_t         exp_tiles[$];
    logic [AW-1:0] exp_addr[$];
    int            n_checks = 0, n_pass = 0;
    bit            stall = 1'b0;

    function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference: tiles and read addresses straight from the row/tile/byte arithmetic.
    task automatic model(input logic [AW-1:0] base, input logic [AW-1:0] strd, input int rb, input int nr);
        int tpr;
        tpr = (rb + NB - 1) / NB;
        for (int r = 0; r < nr; r++) begin
            logic [AW-1:0] rp;
            rp = base + AW'(r) * strd;
            for (int t = 0; t < tpr; t++) begin
                tile_t e;
                e.data = '0;
                for (int j = 0; j < NB; j++)
                    if (t * NB + j < rb) e.data[TW-1-8*j -: 8] = mem_byte(rp + AW'(t * NB + j));
                for (int b = 0; b < BEATS; b++)
                    if (t * NB + b * MB < rb) exp_addr.push_back(rp + AW'(t * NB + b * MB));
                e.rl = (t == tpr - 1);
                e.l  = e.rl && (r == nr - 1);
                exp_tiles.push_back(e);
            end
        end
    endtask

    // Synchronous byte memory with one cycle of read latency.
    always @(posedge clk) begin
        if (mem_en)
            for (int k = 0; k < MB; k++) mem_rdata[8*k +: 8] <= mem_byte(mem_addr + AW'(k));
    end

    always @(posedge clk) begin
        #1;
        tile_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    tile_t prev;
    bit    prev_vld = 1'b0, prev_rdy = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_vld = 1'b0;
        end else begin
            if (mem_en) begin
                check("read_expected", 64'(exp_addr.size() != 0), 64'(1));
                if (exp_addr.size() != 0) check("mem_addr", 64'(mem_addr), 64'(exp_addr.pop_front()));
            end
            if (tile_valid) check("no_read_in_output", 64'(mem_en), 64'(0));
            if (tile_valid && prev_vld && !prev_rdy) begin
                check("hold_data", tile_data, prev.data);
                check("hold_flags", 64'({tile_row_last, tile_last}), 64'({prev.rl, prev.l}));
            end
            if (tile_valid && tile_ready) begin
                check("tile_expected", 64'(exp_tiles.size() != 0), 64'(1));
                if (exp_tiles.size() != 0) begin
                    tile_t e;
                    e = exp_tiles.pop_front();
                    check("tile_data", tile_data, e.data);
                    check("tile_row_last", 64'(tile_row_last), 64'(e.rl));
                    check("tile_last", 64'(tile_last), 64'(e.l));
                end
            end
            prev     = '{data: tile_data, rl: tile_row_last, l: tile_last};
            prev_vld = tile_valid;
            prev_rdy = tile_ready;
        end
    end

    task automatic wait_idle();
        int i;
        for (i = 0; i < 100 && !cmd_ready; i++) begin
            @(posedge clk); #1;
        end
        check("idle_reached", 64'(cmd_ready), 64'(1));
    endtask

    // Issue one command, present a junk command while busy, and follow it to done.
    task automatic run_cmd(input logic [AW-1:0] base, input logic [AW-1:0] strd, input int rb, input int nr,
                           input bit check_lat);
        bit empty;
        bit got_done;
        int first;
        empty = (rb == 0) || (nr == 0);
        model(base, strd, rb, nr);
        wait_idle();
        cmd_base = base; cmd_stride = strd; cmd_row_bytes = LW'(rb); cmd_num_rows = LW'(nr);
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        check("busy_cmd_ready", 64'(cmd_ready), 64'(0));
        cmd_base = AW'($urandom()); cmd_row_bytes = 16'd5; cmd_num_rows = 16'd3;
        got_done = 1'b0;
        first = -1;
        if (empty) begin
            check("empty_done_pulse", 64'(done), 64'(1));
            check("empty_no_read", 64'({mem_en, tile_valid}), 64'(0));
            got_done = done;
            @(posedge clk); #1;
            cmd_valid = 1'b0;
        end else begin
            for (int n = 1; n <= 2000; n++) begin
                @(posedge clk); #1;
                if (n == 1) cmd_valid = 1'b0;
                if (tile_valid && first < 0) first = n;
                if (done) begin
                    got_done = 1'b1;
                    break;
                end
            end
            if (check_lat) check("first_tile_latency", 64'(first), 64'(BEATS + 1));
            check("done_seen", 64'(got_done), 64'(1));
            @(posedge clk); #1;
        end
        check("done_one_cycle", 64'({done, cmd_ready}), 64'(2'b01));
        check("tiles_drained", 64'(exp_tiles.size()), 64'(0));
        check("reads_drained", 64'(exp_addr.size()), 64'(0));
        exp_tiles.delete();
        exp_addr.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_base = '0; cmd_stride = '0; cmd_row_bytes = '0; cmd_num_rows = '0;
        #3;
        check("reset_outputs", 64'({cmd_ready, mem_en, tile_valid, tile_row_last, tile_last, done}), 64'(6'b100000));
        check("reset_data", tile_data | 64'(mem_addr), 64'(0));
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        run_cmd(24'h10, 24'h40, 8, 1, 1'b1);
        run_cmd(24'h10, 24'h40, 13, 2, 1'b1);
        run_cmd(24'h10, 24'h40, 3, 1, 1'b1);

        stall = 1'b1;
        fork
            run_cmd(24'h10, 24'h40, 13, 2, 1'b1);
            begin
                for (int i = 0; i < 100 && !tile_valid; i++) begin
                    @(posedge clk); #1;
                end
                repeat (10) @(posedge clk);
                stall = 1'b0;
            end
        join

        run_cmd(24'h10, 24'h40, 8, 0, 1'b0);
        run_cmd(24'h10, 24'h40, 0, 3, 1'b0);

        // Abort a command while it fetches row 1.
        model(24'h10, 24'h40, 13, 2);
        wait_idle();
        cmd_base = 24'h10; cmd_stride = 24'h40; cmd_row_bytes = 16'd13; cmd_num_rows = 16'd2;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            if (mem_en && mem_addr >= 24'h50) break;
        end
        check("reached_row1", 64'(mem_en && mem_addr >= 24'h50), 64'(1));
        rst = 1'b1;
        #1;
        check("abort_outputs", 64'({cmd_ready, mem_en, tile_valid, tile_row_last, tile_last, done}), 64'(6'b100000));
        check("abort_data", tile_data | 64'(mem_addr), 64'(0));
        exp_tiles.delete();
        exp_addr.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("post_abort_idle", 64'({cmd_ready, done}), 64'(2'b10));
        run_cmd(24'h10, 24'h40, 13, 2, 1'b1);

        run_cmd(24'hFFFFF8, 24'h10, 8, 2, 1'b1);
        run_cmd(24'hFFFFFC, 24'h20, 11, 2, 1'b1);

        for (int i = 0; i < 25; i++)
            run_cmd(AW'($urandom()), AW'($urandom()), int'($urandom_range(0, 30)), int'($urandom_range(0, 4)), 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
